// File: rtl/bpu_btb_ras_pkg.sv
// Shared definitions for the branch prediction unit.
//   - ctype encodings driven by the execute stage (CT_NONE .. CT_RET)
//   - btb_type_e, the 2-bit instruction class stored in each BTB entry
//   - ctype_to_btb(): maps an execute-stage ctype to the stored BTB class
//   - sat_step(): one step of an up/down saturating counter
package bpu_btb_ras_pkg;

    localparam logic [2:0] CT_NONE   = 3'd0;
    localparam logic [2:0] CT_BRANCH = 3'd1;
    localparam logic [2:0] CT_JAL    = 3'd2;
    localparam logic [2:0] CT_JALR   = 3'd3;
    localparam logic [2:0] CT_CALL   = 3'd4;
    localparam logic [2:0] CT_RET    = 3'd5;

    typedef enum logic [1:0] {
        BtBr   = 2'd0,
        BtJmp  = 2'd1,
        BtCall = 2'd2,
        BtRet  = 2'd3
    } btb_type_e;

    // jal/jalr (and any unassigned code) share the unconditional-jump class.
    function automatic btb_type_e ctype_to_btb(input logic [2:0] ctype);
        case (ctype)
            CT_BRANCH: return BtBr;
            CT_CALL:   return BtCall;
            CT_RET:    return BtRet;
            default:   return BtJmp;
        endcase
    endfunction

    function automatic int unsigned sat_step(input int unsigned cnt, input logic up,
                                             input int unsigned cnt_max);
        if (up) begin
            return (cnt >= cnt_max) ? cnt_max : cnt + 1;
        end
        return (cnt == 0) ? 0 : cnt - 1;
    endfunction

endpackage

// File: rtl/bpu_btb_ras_if.sv
// Pipeline-facing bus of the branch prediction unit.
//   Fetch:   pc_f -> pred_taken_f, pred_target_f
//   Execute: valid_e, pc_e, ctype_e, taken_e, target_e, pred_taken_e, pred_target_e
//            -> flush, pc_restore
//   Status:  mispredict_cnt
// master = the core pipeline, slave = the predictor.
interface bpu_btb_ras_if #(
    parameter int unsigned XLEN = 32
);
    logic [XLEN-1:0] pc_f;
    logic            pred_taken_f;
    logic [XLEN-1:0] pred_target_f;

    logic            valid_e;
    logic [XLEN-1:0] pc_e;
    logic [2:0]      ctype_e;
    logic            taken_e;
    logic [XLEN-1:0] target_e;
    logic            pred_taken_e;
    logic [XLEN-1:0] pred_target_e;

    logic            flush;
    logic [XLEN-1:0] pc_restore;
    logic [31:0]     mispredict_cnt;

    modport master (
        output pc_f, valid_e, pc_e, ctype_e, taken_e, target_e, pred_taken_e, pred_target_e,
        input  pred_taken_f, pred_target_f, flush, pc_restore, mispredict_cnt
    );

    modport slave (
        input  pc_f, valid_e, pc_e, ctype_e, taken_e, target_e, pred_taken_e, pred_target_e,
        output pred_taken_f, pred_target_f, flush, pc_restore, mispredict_cnt
    );

endinterface

// File: rtl/bpu_btb_ras_ras_stack.sv
// Circular return address stack.
//   clk, rst   clock, synchronous active-high reset
//   push       write push_addr as the new top
//   pop        discard the top (ignored when empty)
//   push_addr  return address to push
//   top        current top entry (meaningless when empty)
//   empty      no valid entries
// push and pop together replace the top in place. A push when full overwrites
// the oldest entry, which is the slot sp already points at.
module ras_stack #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned XLEN  = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            push,
    input  logic            pop,
    input  logic [XLEN-1:0] push_addr,
    output logic [XLEN-1:0] top,
    output logic            empty
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    logic [XLEN-1:0] mem_q [DEPTH];
    logic [PtrW-1:0] sp_q, sp_d, top_ptr, wr_ptr;
    logic [CntW-1:0] count_q, count_d;
    logic            wr_en;

    // sp points at the next free slot; the top lives one below it.
    assign top_ptr = sp_q - PtrW'(1);
    assign empty   = (count_q == '0);
    assign top     = mem_q[top_ptr];

    always_comb begin
        sp_d    = sp_q;
        count_d = count_q;
        wr_en   = 1'b0;
        wr_ptr  = sp_q;
        if (push && pop) begin
            wr_en  = 1'b1;
            wr_ptr = top_ptr;
        end else if (push) begin
            wr_en = 1'b1;
            sp_d  = sp_q + PtrW'(1);
            if (count_q != CntW'(DEPTH)) begin
                count_d = count_q + CntW'(1);
            end
        end else if (pop && !empty) begin
            sp_d    = top_ptr;
            count_d = count_q - CntW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sp_q    <= '0;
            count_q <= '0;
        end else begin
            sp_q    <= sp_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && wr_en) begin
            mem_q[wr_ptr] <= push_addr;
        end
    end

endmodule

// File: rtl/bpu_btb_ras.sv
// Branch prediction unit: direct-mapped tagged BTB with per-entry saturating
// counters plus a non-speculative return address stack.
//   clk, rst  clock, synchronous active-high reset
//   bus       bpu_btb_ras_if slave modport:
//             fetch lookup (pc_f -> pred_taken_f/pred_target_f),
//             execute resolution (flush/pc_restore) and training,
//             mispredict_cnt (wrapping count of flush cycles)
// The fetch read is asynchronous; an entry written at a clock edge is seen by
// fetch only from the following cycle.
module bpu_btb_ras
    import bpu_btb_ras_pkg::*;
#(
    parameter int unsigned XLEN        = 32,
    parameter int unsigned BTB_ENTRIES = 64,
    parameter int unsigned RAS_DEPTH   = 8,
    parameter int unsigned CNT_BITS    = 2
) (
    input logic           clk,
    input logic           rst,
    bpu_btb_ras_if.slave  bus
);

    localparam int unsigned IDX_W = $clog2(BTB_ENTRIES);
    localparam int unsigned TAG_W = XLEN - IDX_W - 2;

    localparam int unsigned         CntMax   = (1 << CNT_BITS) - 1;
    localparam logic [CNT_BITS-1:0] CntAlloc = CNT_BITS'(1 << (CNT_BITS - 1));
    localparam logic [CNT_BITS-1:0] CntReset = CNT_BITS'((1 << (CNT_BITS - 1)) - 1);

    logic                valid_q  [BTB_ENTRIES];
    logic [TAG_W-1:0]    tag_q    [BTB_ENTRIES];
    logic [XLEN-1:0]     target_q [BTB_ENTRIES];
    btb_type_e           type_q   [BTB_ENTRIES];
    logic [CNT_BITS-1:0] cnt_q    [BTB_ENTRIES];

    logic [IDX_W-1:0]    idx_f, idx_e;
    logic [TAG_W-1:0]    tag_f, tag_e;
    logic                hit_f, hit_e, taken_f;
    logic                is_ctrl, flush_raw;
    logic                wr_en, inv_en;
    logic [CNT_BITS-1:0] wr_cnt;
    logic [XLEN-1:0]     ras_top;
    logic                ras_empty, ras_push, ras_pop;
    logic [31:0]         mispredict_cnt_q;
    logic                unused_pc_lsbs;

    assign unused_pc_lsbs = ^{bus.pc_f[1:0], bus.pc_e[1:0]};

    // Fetch lookup.
    assign idx_f   = bus.pc_f[IDX_W+1:2];
    assign tag_f   = bus.pc_f[XLEN-1:IDX_W+2];
    assign hit_f   = valid_q[idx_f] && (tag_q[idx_f] == tag_f);
    assign taken_f = hit_f && ((type_q[idx_f] != BtBr) || cnt_q[idx_f][CNT_BITS-1]);

    assign bus.pred_taken_f = taken_f;

    always_comb begin
        bus.pred_target_f = bus.pc_f + XLEN'(4);
        if (taken_f) begin
            if ((type_q[idx_f] == BtRet) && !ras_empty) begin
                bus.pred_target_f = ras_top;
            end else begin
                bus.pred_target_f = target_q[idx_f];
            end
        end
    end

    // Execute-stage resolution.
    assign idx_e   = bus.pc_e[IDX_W+1:2];
    assign tag_e   = bus.pc_e[XLEN-1:IDX_W+2];
    assign hit_e   = valid_q[idx_e] && (tag_e == tag_q[idx_e]);
    assign is_ctrl = (bus.ctype_e != CT_NONE);

    // A predicted-taken non-control instruction means fetch hit an aliased entry.
    assign flush_raw = bus.valid_e &&
                       (is_ctrl ? ((bus.taken_e != bus.pred_taken_e) ||
                                   (bus.taken_e && (bus.target_e != bus.pred_target_e)))
                                : bus.pred_taken_e);

    assign bus.flush      = !rst && flush_raw;
    assign bus.pc_restore = rst ? '0 : (bus.taken_e ? bus.target_e : bus.pc_e + XLEN'(4));

    // BTB training decision.
    always_comb begin
        wr_en  = 1'b0;
        inv_en = 1'b0;
        wr_cnt = cnt_q[idx_e];
        if (bus.valid_e) begin
            if (is_ctrl) begin
                if (hit_e) begin
                    wr_en  = 1'b1;
                    wr_cnt = CNT_BITS'(sat_step(32'(cnt_q[idx_e]), bus.taken_e, CntMax));
                end else if (bus.taken_e) begin
                    wr_en  = 1'b1;
                    wr_cnt = CntAlloc;
                end
            end else if (hit_e) begin
                inv_en = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(BTB_ENTRIES); i++) begin
                valid_q[i] <= 1'b0;
                cnt_q[i]   <= CntReset;
            end
        end else if (wr_en) begin
            valid_q[idx_e] <= 1'b1;
            cnt_q[idx_e]   <= wr_cnt;
        end else if (inv_en) begin
            valid_q[idx_e] <= 1'b0;
        end
    end

    // Payload fields need no reset: they are only read behind valid.
    always_ff @(posedge clk) begin
        if (!rst && wr_en) begin
            tag_q[idx_e]    <= tag_e;
            target_q[idx_e] <= bus.target_e;
            type_q[idx_e]   <= ctype_to_btb(bus.ctype_e);
        end
    end

    // Return address stack, trained from resolved instructions only.
    assign ras_push = bus.valid_e && (bus.ctype_e == CT_CALL);
    assign ras_pop  = bus.valid_e && (bus.ctype_e == CT_RET);

    ras_stack #(
        .DEPTH (RAS_DEPTH),
        .XLEN  (XLEN)
    ) u_ras (
        .clk       (clk),
        .rst       (rst),
        .push      (ras_push),
        .pop       (ras_pop),
        .push_addr (bus.pc_e + XLEN'(4)),
        .top       (ras_top),
        .empty     (ras_empty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            mispredict_cnt_q <= '0;
        end else if (bus.flush) begin
            mispredict_cnt_q <= mispredict_cnt_q + 32'd1;
        end
    end

    assign bus.mispredict_cnt = mispredict_cnt_q;

endmodule
